// File: rtl/pc_ras_unit_pkg.sv
// Shared definitions for the program-counter unit: PC source encodings,
// trap FSM state type and default reset/trap vectors.
package pc_ras_unit_pkg;

    // PCSrc encodings
    localparam logic [2:0] PC_SEQ    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_REG    = 3'd3;
    localparam logic [2:0] PC_CALL   = 3'd4;
    localparam logic [2:0] PC_RET    = 3'd5;
    localparam logic [2:0] PC_TRAP   = 3'd6;
    localparam logic [2:0] PC_ERET   = 3'd7;

    // Trap FSM states
    typedef enum logic {
        NORMAL = 1'b0,
        TRAP   = 1'b1
    } pc_state_e;

    // Default vectors (truncated/extended to ADDR_W at the use site)
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Push writes at the pointer and advances it;
// pop steps the pointer back and the entry below the pointer is the top.
// When full, a push overwrites the oldest entry and the count saturates.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pop_ok;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(RAS_DEPTH));
    assign top    = mem_q[ptr_q - PW'(1)];
    // A pop on an empty stack must not disturb pointer or count
    assign pop_ok = pop && !empty;

    // Next pointer and saturating count
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop_ok) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer and count registers, falling-edge clocked
    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below the count
    always_ff @(negedge CLK) begin
        if (push) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Program-counter unit: sequential/branch/jump/register-jump selection,
// call/return through a return-address stack, trap/eret with a saved EPC,
// and a level interrupt that is masked while in the trap state.
module pc_ras_unit
    import pc_ras_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       IMM_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(DEF_TRAP_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic [2:0]        PCSrc,
    input  logic [IMM_W-1:0]  Immediate,
    input  logic [ADDR_W-1:0] JumpPC,
    input  logic [ADDR_W-1:0] RegPC,
    input  logic              IrqReq,
    output logic [ADDR_W-1:0] InsAddr,
    output logic [ADDR_W-1:0] nextPC,
    output logic [3:0]        PC4,
    output logic [ADDR_W-1:0] EPC,
    output logic              InTrap,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              RasMiss,
    output logic              DoubleFault
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              miss_q, miss_d;
    logic              df_q, df_d;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] sel_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;
    logic              push_req, pop_req, miss_req;
    logic              irq_take;
    logic              ras_push, ras_pop;

    assign seq_pc    = pc_q + ADDR_W'(4);
    assign imm_ext   = {{(ADDR_W - IMM_W){Immediate[IMM_W-1]}}, Immediate};
    assign branch_pc = seq_pc + (imm_ext << 2);
    assign irq_take  = IrqReq && (state_q == NORMAL);

    // Target that PCSrc alone would select, plus stack side effects requested
    always_comb begin
        sel_pc   = seq_pc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        miss_req = 1'b0;
        unique case (PCSrc)
            PC_SEQ:    sel_pc = seq_pc;
            PC_BRANCH: sel_pc = branch_pc;
            PC_JUMP:   sel_pc = JumpPC;
            PC_REG:    sel_pc = RegPC;
            PC_CALL: begin
                sel_pc   = JumpPC;
                push_req = 1'b1;
            end
            PC_RET: begin
                if (ras_empty) begin
                    sel_pc   = RegPC;
                    miss_req = 1'b1;
                end else begin
                    sel_pc  = ras_top;
                    pop_req = 1'b1;
                end
            end
            PC_TRAP:   sel_pc = TRAP_VEC;
            PC_ERET:   sel_pc = (state_q == TRAP) ? epc_q : seq_pc;
            default:   sel_pc = seq_pc;
        endcase
    end

    // An accepted interrupt redirects to the trap vector and suppresses stack effects
    always_comb begin
        nextPC   = irq_take ? TRAP_VEC : sel_pc;
        ras_push = PCWrite && push_req && !irq_take;
        ras_pop  = PCWrite && pop_req && !irq_take;
        miss_d   = PCWrite && miss_req && !irq_take;
    end

    // Trap FSM next state plus EPC and double-fault updates
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        df_d    = df_q;
        unique case (state_q)
            NORMAL: begin
                if (irq_take) begin
                    state_d = TRAP;
                    epc_d   = sel_pc;
                end else if (PCSrc == PC_TRAP) begin
                    state_d = TRAP;
                    epc_d   = seq_pc;
                end
            end
            TRAP: begin
                if (PCSrc == PC_ERET) begin
                    state_d = NORMAL;
                end else if (PCSrc == PC_TRAP) begin
                    // Nested trap keeps the original return address
                    df_d = 1'b1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    // Falling-edge architectural state; PCWrite=0 holds everything but the miss pulse
    always_ff @(negedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= NORMAL;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            miss_q  <= 1'b0;
            df_q    <= 1'b0;
        end else begin
            miss_q <= miss_d;
            if (PCWrite) begin
                state_q <= state_d;
                pc_q    <= nextPC;
                epc_q   <= epc_d;
                df_q    <= df_d;
            end
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .CLK       (CLK),
        .Reset     (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Output mapping
    always_comb begin
        InsAddr     = pc_q;
        PC4         = pc_q[ADDR_W-1:ADDR_W-4];
        EPC         = epc_q;
        InTrap      = (state_q == TRAP);
        RasEmpty    = ras_empty;
        RasFull     = ras_full;
        RasMiss     = miss_q;
        DoubleFault = df_q;
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit. Expected fetch addresses are queued as each
// step is driven and popped after the falling edge that should produce them.
module tb_pc_ras_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic [2:0]  PCSrc;
    logic [15:0] Immediate;
    logic [31:0] JumpPC;
    logic [31:0] RegPC;
    logic        IrqReq;
    logic [31:0] InsAddr;
    logic [31:0] nextPC;
    logic [3:0]  PC4;
    logic [31:0] EPC;
    logic        InTrap;
    logic        RasEmpty;
    logic        RasFull;
    logic        RasMiss;
    logic        DoubleFault;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [31:0] exp_q[$];

    pc_ras_unit #(
        .ADDR_W    (32),
        .IMM_W     (16),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0080),
        .RAS_DEPTH (4)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .Immediate   (Immediate),
        .JumpPC      (JumpPC),
        .RegPC       (RegPC),
        .IrqReq      (IrqReq),
        .InsAddr     (InsAddr),
        .nextPC      (nextPC),
        .PC4         (PC4),
        .EPC         (EPC),
        .InTrap      (InTrap),
        .RasEmpty    (RasEmpty),
        .RasFull     (RasFull),
        .RasMiss     (RasMiss),
        .DoubleFault (DoubleFault)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    // Wait for the active (falling) edge, then compare InsAddr with the queued value
    task automatic edge_chk(input string tag);
        @(negedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s: got %h, want <queued value>", tag, InsAddr);
        end else begin
            check(tag, InsAddr, exp_q.pop_front());
        end
    endtask

    task automatic go(input string tag, input logic [2:0] src, input logic [31:0] jpc,
                      input logic [31:0] rpc, input logic [31:0] exp_pc);
        PCSrc  = src;
        JumpPC = jpc;
        RegPC  = rpc;
        exp_q.push_back(exp_pc);
        edge_chk(tag);
    endtask

    initial begin
        Reset     = 1'b1;
        PCWrite   = 1'b0;
        PCSrc     = 3'd0;
        Immediate = '0;
        JumpPC    = '0;
        RegPC     = '0;
        IrqReq    = 1'b0;
        #1 Reset = 1'b0;
        #2;
        check("rst_insaddr", InsAddr, 32'h0);
        check("rst_epc", EPC, 32'h0);
        check("rst_intrap", InTrap, 1'b0);
        check("rst_rasempty", RasEmpty, 1'b1);
        check("rst_rasfull", RasFull, 1'b0);
        check("rst_rasmiss", RasMiss, 1'b0);
        check("rst_df", DoubleFault, 1'b0);
        Reset   = 1'b1;
        PCWrite = 1'b1;
        #1;
        check("seq_nextpc", nextPC, 32'h4);

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            go("seq", 3'd0, 32'h0, 32'h0, 32'(i * 4));
        end
        check("seq_pc4", PC4, 4'h0);

        // Branch arithmetic at 0x100 (combinational only)
        go("jump_100", 3'd2, 32'h100, 32'h0, 32'h100);
        PCSrc     = 3'd1;
        Immediate = 16'hFFFE;
        #1 check("br_neg", nextPC, 32'h0000_00FC);
        Immediate = 16'h7FFF;
        #1 check("br_maxpos", nextPC, 32'h0002_0100);
        Immediate = 16'hFFFE;
        go("br_taken", 3'd1, 32'h0, 32'h0, 32'h0000_00FC);

        // Address wrap from the top of the space
        go("jump_top", 3'd2, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
        check("pc4_top", PC4, 4'hF);
        go("seq_wrap", 3'd0, 32'h0, 32'h0, 32'h0);

        // Nested call/return and return miss
        go("jump_10", 3'd2, 32'h10, 32'h0, 32'h10);
        go("call_400", 3'd4, 32'h400, 32'h0, 32'h400);
        go("call_500", 3'd4, 32'h500, 32'h0, 32'h500);
        go("ret_1", 3'd5, 32'h0, 32'h0, 32'h404);
        go("ret_2", 3'd5, 32'h0, 32'h0, 32'h14);
        check("ras_empty_after_rets", RasEmpty, 1'b1);
        go("ret_miss", 3'd5, 32'h0, 32'h900, 32'h900);
        check("rasmiss_pulse", RasMiss, 1'b1);
        check("ras_empty_after_miss", RasEmpty, 1'b1);
        go("seq_after_miss", 3'd0, 32'h0, 32'h0, 32'h904);
        check("rasmiss_drop", RasMiss, 1'b0);

        // Overflow: five calls into a four-entry stack
        go("call_a", 3'd4, 32'h1000, 32'h0, 32'h1000);
        go("call_b", 3'd4, 32'h2000, 32'h0, 32'h2000);
        go("call_c", 3'd4, 32'h3000, 32'h0, 32'h3000);
        check("rasfull_3", RasFull, 1'b0);
        go("call_d", 3'd4, 32'h4000, 32'h0, 32'h4000);
        check("rasfull_4", RasFull, 1'b1);
        go("call_e", 3'd4, 32'h5000, 32'h0, 32'h5000);
        check("rasfull_5", RasFull, 1'b1);
        go("ret_e", 3'd5, 32'h0, 32'h0, 32'h4004);
        check("rasfull_after_pop", RasFull, 1'b0);
        go("ret_d", 3'd5, 32'h0, 32'h0, 32'h3004);
        go("ret_c", 3'd5, 32'h0, 32'h0, 32'h2004);
        go("ret_b", 3'd5, 32'h0, 32'h0, 32'h1004);
        check("ras_empty_after_ovf", RasEmpty, 1'b1);

        // Interrupt overrides a call; no push happens
        go("jump_40", 3'd2, 32'h40, 32'h0, 32'h40);
        IrqReq = 1'b1;
        PCSrc  = 3'd4;
        JumpPC = 32'h600;
        #1 check("irq_nextpc", nextPC, 32'h80);
        go("irq_take", 3'd4, 32'h600, 32'h0, 32'h80);
        check("irq_epc", EPC, 32'h600);
        check("irq_intrap", InTrap, 1'b1);
        check("irq_no_push", RasEmpty, 1'b1);
        check("irq_no_miss", RasMiss, 1'b0);
        go("irq_masked", 3'd0, 32'h0, 32'h0, 32'h84);
        check("irq_masked_epc", EPC, 32'h600);
        IrqReq = 1'b0;
        go("double_trap", 3'd6, 32'h0, 32'h0, 32'h80);
        check("df_set", DoubleFault, 1'b1);
        check("df_epc", EPC, 32'h600);
        go("eret_1", 3'd7, 32'h0, 32'h0, 32'h600);
        check("eret_intrap", InTrap, 1'b0);
        check("df_sticky", DoubleFault, 1'b1);

        // Synchronous trap from NORMAL saves seq; eret in NORMAL is seq
        go("trap", 3'd6, 32'h0, 32'h0, 32'h80);
        check("trap_epc", EPC, 32'h604);
        go("eret_2", 3'd7, 32'h0, 32'h0, 32'h604);
        go("eret_normal", 3'd7, 32'h0, 32'h0, 32'h608);

        // RasMiss drops on a held edge; PCWrite=0 freezes PC and stack
        go("miss_2", 3'd5, 32'h0, 32'h800, 32'h800);
        check("rasmiss_2", RasMiss, 1'b1);
        PCWrite = 1'b0;
        go("hold_0", 3'd4, 32'h700, 32'h0, 32'h800);
        check("rasmiss_hold_drop", RasMiss, 1'b0);
        go("hold_1", 3'd4, 32'h700, 32'h0, 32'h800);
        go("hold_2", 3'd4, 32'h700, 32'h0, 32'h800);
        check("hold_ras", RasEmpty, 1'b1);
        check("hold_df", DoubleFault, 1'b1);

        // Asynchronous reset between edges
        Reset = 1'b0;
        #1;
        check("arst_insaddr", InsAddr, 32'h0);
        check("arst_df", DoubleFault, 1'b0);
        check("arst_epc", EPC, 32'h0);
        Reset   = 1'b1;
        PCWrite = 1'b1;
        go("post_rst_seq", 3'd0, 32'h0, 32'h0, 32'h4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program-counter unit for the single-cycle CPU datapath. It extends sequential, branch and jump selection with register jumps, call/return through an internal return-address stack (RAS), a trap vector with a saved exception PC (EPC), and an external interrupt request. It feeds the instruction-memory address, and it supplies the next-PC and upper PC bits to the jump-address builder.

Parameters:
ADDR_W, 32, PC and address width
IMM_W, 16, branch offset width (signed word offset)
RESET_VEC, 0, InsAddr value after reset
TRAP_VEC, 32'h0000_0080, target for trap or interrupt
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
CLK  in  1  clock; all state updates on the falling edge
Reset  in  1  asynchronous, active-low reset
PCWrite  in  1  update enable; 0 = full hold, including RAS, EPC and FSM
PCSrc  in  3  0 seq, 1 branch, 2 jump, 3 reg-jump, 4 call, 5 return, 6 trap, 7 eret
Immediate  in  IMM_W  signed branch word offset
JumpPC  in  ADDR_W  absolute jump/call target
RegPC  in  ADDR_W  register-file jump target
IrqReq  in  1  level interrupt request
InsAddr  out  ADDR_W  current fetch address (registered)
nextPC  out  ADDR_W  combinational value InsAddr takes at the next active edge if PCWrite=1
PC4  out  4  InsAddr[ADDR_W-1:ADDR_W-4]
EPC  out  ADDR_W  saved exception return address (registered)
InTrap  out  1  FSM is in TRAP
RasEmpty  out  1  RAS count == 0
RasFull  out  1  RAS count == RAS_DEPTH
RasMiss  out  1  registered one-edge pulse: return executed with RAS empty
DoubleFault  out  1  sticky; trap/irq taken while InTrap

Behaviour:
- Reset (async, Reset=0): InsAddr=RESET_VEC, EPC=0, FSM=NORMAL, RAS count=0, RAS pointer=0, RasMiss=0, DoubleFault=0. A reset asserted mid-operation clears everything immediately.
- seq = InsAddr+4. Branch target = InsAddr+4+(sext(Immediate)<<2). All sums are modulo 2^ADDR_W; wrap from all-ones is legal and silent.
- Target selection:
  - 0 seq; 1 branch; 2 JumpPC; 3 RegPC.
  - 4 call: JumpPC; push seq.
  - 5 return: top of RAS with pop. If the RAS is empty, use RegPC, keep count at 0 and pulse RasMiss.
  - 6 trap: TRAP_VEC.
  - 7 eret: EPC when in TRAP; treated as seq when in NORMAL.
- Interrupt: IrqReq=1 in NORMAL overrides PCSrc. nextPC=TRAP_VEC and EPC=the target PCSrc would have selected. No push/pop and no RasMiss occur.
- IrqReq is ignored in TRAP, so interrupts are masked until eret.
- FSM NORMAL->TRAP on trap (EPC=seq) or accepted irq. TRAP->NORMAL on eret.
- Trap in TRAP: go to TRAP_VEC, leave EPC unchanged, set DoubleFault. DoubleFault is cleared only by reset.
- RAS is circular. Push writes at the pointer, advances the pointer, and saturates count at RAS_DEPTH. A push when full overwrites the oldest entry silently. Pop decrements the pointer, then reads.
- Latency: InsAddr reflects a selection one falling edge after it is presented. nextPC is valid combinationally in the same cycle. RasMiss is high for exactly one cycle after the offending edge.
- PCWrite=0: no register changes. RasMiss deasserts at that edge.

Decomposition:
- Shared package: PCSrc encodings (PC_SEQ..PC_ERET), FSM state typedef (NORMAL, TRAP), and default RESET_VEC and TRAP_VEC constants.
- One sub-module, ras_stack: parameters RAS_DEPTH and ADDR_W; ports push, pop, push_data, top, empty, full, with circular pointer and saturating count. All PC selection and the FSM stay in pc_ras_unit.

Test Plan:
- Reset release, four edges with PCSrc=0 -> InsAddr 0,4,8,12,16; PC4=0.
- InsAddr=0x100, Immediate=-2, PCSrc=1 -> nextPC=0xFC; InsAddr=0x100, Immediate=0x7FFF -> nextPC=0x20100.
- Calls to 0x400, 0x500 from 0x10 and 0x400, then return twice -> InsAddr 0x404 then 0x14; RasEmpty=1. A third return with RegPC=0x900 -> 0x900 and a RasMiss pulse.
- Five calls with RAS_DEPTH=4, then four returns -> addresses of calls 5,4,3,2 returned; RasFull=1 after the fourth push.
- IrqReq=1 with PCSrc=4 at 0x40 -> InsAddr=0x80, EPC=JumpPC, no push. Trap while InTrap -> DoubleFault=1, EPC unchanged. eret -> InsAddr=EPC, InTrap=0.
- PCWrite=0 for 3 edges with PCSrc=4 -> InsAddr and RAS unchanged. Reset asserted between edges -> InsAddr=RESET_VEC immediately.
